// File: rtl/mult_pkg.sv
// Shared definitions for the nibble-serial 8x8 multiplier: FSM encoding,
// default nibble width and the per-step partial-product shift.
package mult_pkg;

    localparam int HALF_W_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CYC0 = 3'd1,
        S_CYC1 = 3'd2,
        S_CYC2 = 3'd3,
        S_CYC3 = 3'd4
    } state_t;

    // Shift of each partial product, counted in nibbles (multiply by HALF_W for bits)
    localparam int SH_CYC0 = 0;
    localparam int SH_CYC1 = 1;
    localparam int SH_CYC2 = 1;
    localparam int SH_CYC3 = 2;

endpackage

// File: rtl/mult4x4.sv
// Combinational unsigned HALF_W x HALF_W multiplier shared by the sequential core.
module mult4x4 #(
    parameter int HALF_W = 4
) (
    input  logic [HALF_W-1:0]   a,
    input  logic [HALF_W-1:0]   b,
    output logic [2*HALF_W-1:0] p
);

    assign p = {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};

endmodule

// File: rtl/mult8x8_seq.sv
// Sequential 8x8 unsigned multiplier: four nibble-pair products from one
// shared mult4x4 are shifted and accumulated over four clocks.
module mult8x8_seq
    import mult_pkg::*;
#(
    parameter int HALF_W = HALF_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2*HALF_W-1:0] dataa,
    input  logic [2*HALF_W-1:0] datab,
    output logic [4*HALF_W-1:0] product,
    output logic                done,
    output logic                busy,
    output logic [2:0]          state_o
);

    localparam int OP_W = 2 * HALF_W;
    localparam int PR_W = 4 * HALF_W;

    // Handshake: start is sampled only in IDLE; busy covers the four compute
    // cycles; done pulses for one cycle in IDLE as product updates, so busy
    // and done are never high together.

    state_t            state, state_nxt;
    logic [OP_W-1:0]   a_q, b_q;
    logic [PR_W-1:0]   acc, product_q, pp_sh;
    logic [HALF_W-1:0] nib_a, nib_b;
    logic [OP_W-1:0]   pp;
    logic              done_q;
    int                sh_nib;

    always_comb begin
        nib_a  = a_q[HALF_W-1:0];
        nib_b  = b_q[HALF_W-1:0];
        sh_nib = SH_CYC0;
        case (state)
            S_CYC1: begin
                nib_a  = a_q[OP_W-1:HALF_W];
                sh_nib = SH_CYC1;
            end
            S_CYC2: begin
                nib_b  = b_q[OP_W-1:HALF_W];
                sh_nib = SH_CYC2;
            end
            S_CYC3: begin
                nib_a  = a_q[OP_W-1:HALF_W];
                nib_b  = b_q[OP_W-1:HALF_W];
                sh_nib = SH_CYC3;
            end
            default: ;
        endcase
    end

    mult4x4 #(.HALF_W(HALF_W)) u_mult4x4 (
        .a (nib_a),
        .b (nib_b),
        .p (pp)
    );

    assign pp_sh = {{(PR_W-OP_W){1'b0}}, pp} << (sh_nib * HALF_W);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CYC0;
            S_CYC0:  state_nxt = S_CYC1;
            S_CYC1:  state_nxt = S_CYC2;
            S_CYC2:  state_nxt = S_CYC3;
            S_CYC3:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q <= dataa;
                        b_q <= datab;
                        acc <= '0;
                    end
                end
                S_CYC0, S_CYC1, S_CYC2: acc <= acc + pp_sh;
                S_CYC3: begin
                    product_q <= acc + pp_sh;
                    done_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign product = product_q;
    assign done    = done_q;
    assign busy    = (state != S_IDLE);
    assign state_o = state;

endmodule

// File: tb/tb_mult8x8_seq.sv
// Directed bench for mult8x8_seq: vector table plus hand-written sequences for
// busy-start, back-to-back, mid-operation reset and operand scrambling.
module tb_mult8x8_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  dataa, datab;
    logic [15:0] product;
    logic        done, busy;
    logic [2:0]  state_o;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[9];

    mult8x8_seq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .dataa   (dataa),
        .datab   (datab),
        .product (product),
        .done    (done),
        .busy    (busy),
        .state_o (state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // mode 0: plain; 1: extra start pulse during CYC1; 2: scramble inputs each cycle
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input int mode);
        logic [15:0] want;
        @(negedge clk);
        dataa = a;
        datab = b;
        start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("state_cyc0", state_o, 1);
        check("done_low_cyc0", done, 0);
        for (int k = 1; k <= 4; k++) begin
            if (mode == 1 && k == 2) begin
                start = 1'b1;
                dataa = 8'hFF;
                datab = 8'h01;
            end else if (mode == 1 && k == 3) begin
                start = 1'b0;
            end
            if (mode == 2) begin
                dataa = 8'($urandom_range(0, 255));
                datab = 8'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
            if (k < 4) begin
                check("busy_mid", busy, 1);
                check("done_mid", done, 0);
                check("state_mid", state_o, 32'(k + 1));
            end else begin
                want = exp_q.pop_front();
                check("done_pulse", done, 1);
                check("busy_at_done", busy, 0);
                check("state_at_done", state_o, 0);
                check("product", product, want);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("state_idle_after", state_o, 0);
        check("product_hold", product, exp);
    endtask

    initial begin
        logic [7:0]  bb_a[3];
        logic [7:0]  bb_b[3];
        logic [15:0] bb_e[3];
        logic [15:0] want;
        logic        saw_done;

        vecs[0] = '{8'h12, 8'h34, 16'h03A8};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{8'hA5, 8'h5A, 16'h3A02};
        vecs[3] = '{8'h00, 8'h7F, 16'h0000};
        vecs[4] = '{8'h01, 8'h01, 16'h0001};
        vecs[5] = '{8'h0F, 8'hF0, 16'h0E10};
        vecs[6] = '{8'hF0, 8'h0F, 16'h0E10};
        vecs[7] = '{8'h80, 8'h02, 16'h0100};
        vecs[8] = '{8'h07, 8'h09, 16'h003F};

        reset = 1'b1;
        start = 1'b0;
        dataa = '0;
        datab = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_product", product, 0);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_state", state_o, 0);
        reset = 1'b0;

        // idle with start low: nothing moves
        repeat (2) @(posedge clk);
        #1;
        check("idle_stays", state_o, 0);

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, 0);

        // start pulse while busy must be ignored
        run_op(8'h10, 8'h10, 16'h0100, 1);

        // operands changing mid-operation must not matter
        run_op(8'hC3, 8'h3C, 16'h2DB4, 2);
        run_op(8'h99, 8'h66, 16'h3CF6, 2);

        // back-to-back with start held high
        bb_a[0] = 8'h11; bb_b[0] = 8'h22; bb_e[0] = 16'h0242;
        bb_a[1] = 8'hFE; bb_b[1] = 8'h03; bb_e[1] = 16'h02FA;
        bb_a[2] = 8'h40; bb_b[2] = 8'h40; bb_e[2] = 16'h1000;
        @(negedge clk);
        dataa = bb_a[0];
        datab = bb_b[0];
        start = 1'b1;
        exp_q.push_back(bb_e[0]);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("b2b_state_cyc0", state_o, 1);
            for (int k = 1; k <= 4; k++) begin
                @(posedge clk); #1;
                if (k == 4) begin
                    want = exp_q.pop_front();
                    check("b2b_done", done, 1);
                    check("b2b_product", product, want);
                    if (i < 2) begin
                        dataa = bb_a[i+1];
                        datab = bb_b[i+1];
                        exp_q.push_back(bb_e[i+1]);
                    end else begin
                        start = 1'b0;
                    end
                end
            end
        end
        @(posedge clk); #1;
        check("b2b_idle_after", state_o, 0);

        // reset during CYC2 aborts with no done pulse
        @(negedge clk);
        dataa = 8'h33;
        datab = 8'h44;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_state_cyc2", state_o, 3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_product", product, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_state", state_o, 0);
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);
        check("abort_product_held", product, 0);

        // normal operation resumes after an abort
        run_op(8'h12, 8'h34, 16'h03A8, 0);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult8x8_seq.md
Name: mult8x8_seq

Overview:
Sequential 8x8 unsigned multiplier built around one shared 4x4 combinational multiplier (`mult4x4`). An FSM steps the four nibble pairs through that multiplier over four clocks and shifts each partial product into a 16-bit accumulator. It presents a start/busy/done handshake to the surrounding datapath, so the 8x8 product costs one small multiplier instead of a full array.

Parameters:
- HALF_W, 4: nibble width fed to the shared multiplier.
- Operand width is 2*HALF_W and product width is 4*HALF_W; all values below assume the default.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- dataa  input  8  multiplicand; captured on accepted start.
- datab  input  8  multiplier; captured on accepted start.
- product  output  16  last completed result; held until the next completion.
- done  output  1  one-cycle pulse when product updates.
- busy  output  1  high while a multiply is in progress.
- state_o  output  3  current FSM state, for debug/LEDs.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - state=IDLE; product=0, done=0, busy=0, state_o=IDLE code.
  - Operand registers and accumulator cleared.
- States: IDLE, CYC0, CYC1, CYC2, CYC3. Encodings 0..4 appear on state_o.
- IDLE:
  - start=1 at edge T: latch dataa/datab, clear acc, go to CYC0, busy<=1.
  - start=0: stay in IDLE; product holds.
- Each CYCn state drives the shared multiplier with one nibble pair; acc <= acc + (pp << shift):
  - CYC0: a[3:0]*b[3:0], shift 0.
  - CYC1: a[7:4]*b[3:0], shift 4.
  - CYC2: a[3:0]*b[7:4], shift 4.
  - CYC3: a[7:4]*b[7:4], shift 8.
- CYC3 exit at edge T+4:
  - product <= acc + (pp3 << 8).
  - done <= 1 for exactly one cycle; busy <= 0; state <= IDLE.
- Latency: start sampled at edge T, product valid and done=1 in the cycle after edge T+4. Throughput is one result per 5 clocks.
- busy is 1 from the cycle after edge T through the cycle after edge T+3; it is never high together with done.
- Arithmetic:
  - Each partial product is 8-bit unsigned, zero-extended to 16 bits before shifting.
  - The accumulator is 16 bits and cannot overflow (max 0xFF*0xFF=0xFE01).
- Boundary conditions:
  - start while busy: ignored, no effect on operands or sequence.
  - start held high continuously: a new multiply begins in the cycle done is high (state is IDLE), giving back-to-back operation.
  - dataa/datab changing mid-operation: no effect; only the latched copies are used.
  - reset mid-operation: abort, all outputs to reset values next cycle, no done pulse.
  - product is not cleared by start; it changes only on completion or reset.

Decomposition:
- Shared package `mult_pkg`:
  - state encoding localparams (S_IDLE=0, S_CYC0..S_CYC3=1..4).
  - HALF_W default.
  - shift-amount constants per state.
- Sub-module: one instance of the existing combinational `mult4x4` for the partial product.
- Nibble-select mux, shifter, accumulator and FSM stay in mult8x8_seq.

Test Plan:
- Reset, then start with a=0x12, b=0x34 -> busy high 4 cycles, done pulse in the cycle after edge T+4, product=0x03A8.
- a=0xFF, b=0xFF -> product=0xFE01; a=0xA5, b=0x5A -> product=0x3A02; a=0x00, b=0x7F -> product=0x0000.
- Start a=0x10,b=0x10; pulse start with a=0xFF,b=0x01 during CYC1 -> pulse ignored, product=0x0100 from the first operands.
- start held high with new operands presented on each done cycle -> results every 5 clocks, each product matches its own operands.
- Assert reset during CYC2 -> next cycle product=0, busy=0, done=0, state_o=0; no done pulse follows.
- Change dataa/datab every cycle during CYC0..CYC3 -> product equals the operands latched at start.
